// File: rtl/mux_arb_2x1.sv
// mux_arb_2x1: two-channel packet arbiter with a registered 2:1 output stage.
// A channel is granted for a whole packet (beats up to and including last).
// Round-robin applies on simultaneous requests, and the output register
// breaks the timing path to the consumer.
//
// Handshake rule for every valid/ready pair in this block: a beat moves on a
// rising clk edge when valid and ready are both high at that edge. valid must
// not wait for ready. Data and last are qualified by valid only.
module mux_arb_2x1 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             last_grant;
    logic             run;
    logic             can_accept;
    logic             gnt_vld;
    logic             gnt_ch;
    logic             acc;
    logic             acc_last;
    logic [WIDTH-1:0] acc_data;

    assign state_dbg = state;

    // State register; reset drops any lock immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grant selection: IDLE arbitrates (round-robin on a tie), LOCKn serves only n.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = 1'b0;
        case (state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = ~last_grant;
                end else if (in0_valid) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = 1'b0;
                end else if (in1_valid) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = 1'b1;
                end
            end
            LOCK0: begin
                gnt_vld = 1'b1;
                gnt_ch  = 1'b0;
            end
            LOCK1: begin
                gnt_vld = 1'b1;
                gnt_ch  = 1'b1;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt_ch  = 1'b0;
            end
        endcase
    end

    // Output decode: readies for the granted channel and the accepted beat mux.
    // run holds readies low until the first clock edge after reset release.
    always_comb begin
        can_accept = !out_valid || out_ready;
        in0_ready  = run && can_accept && gnt_vld && !gnt_ch;
        in1_ready  = run && can_accept && gnt_vld && gnt_ch;
        acc        = gnt_ch ? (in1_valid && in1_ready) : (in0_valid && in0_ready);
        acc_data   = gnt_ch ? in1_data : in0_data;
        acc_last   = gnt_ch ? in1_last : in0_last;
    end

    // Next state: lock on a non-final first beat, unlock on the final beat.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (acc && !acc_last) begin
                    state_nxt = gnt_ch ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (acc && acc_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping: sel follows each grant, last_grant updates at packet end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            last_grant <= 1'b1;
            run        <= 1'b0;
        end else begin
            run <= 1'b1;
            if (acc) begin
                sel <= gnt_ch;
                if (acc_last) begin
                    last_grant <= gnt_ch;
                end
            end
        end
    end

    // Output register: load on accept (also while draining), clear valid on drain only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= acc_data;
            out_last  <= acc_last;
            out_src   <= gnt_ch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
